// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Purpose : shared definitions for the pipeline hazard controller.
//           Holds the controller state encoding, the register-number width
//           and the opcode a stage register loads when it is told to take
//           a NOP.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 3;

    // Opcode a stage register inserts on flush/bubble.
    localparam logic [5:0] NOP_OPCODE = 6'd0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// ----------------------------------------------------------------------------
// hazard_cmp
// Purpose : combinational RAW comparator for one producing stage.
// Ports   :
//   rs_i, rt_i         decode source register numbers
//   use_rs_i, use_rt_i decode actually reads Rs / Rt
//   rd_i               destination register of the producing stage
//   wr_i               producing stage will write rd_i (already qualified)
//   match_o            decode depends on the producing stage
// R0 is an ordinary register here, so no zero-register exclusion.
// ----------------------------------------------------------------------------
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             use_rs_i,
    input  logic             use_rt_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             wr_i,
    output logic             match_o
);

    assign match_o = wr_i & ((use_rs_i & (rs_i == rd_i)) |
                             (use_rt_i & (rt_i == rd_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Purpose : central stall/flush controller for the 5-stage core. Detects RAW
//           hazards, arbitrates memory freeze / branch flush / fetch stall /
//           data stall, sequences the HALT drain and counts stall cycles.
// Parameters:
//   FORWARD   1: bypass present, only load-use stalls; 0: stall on any RAW
//   DRAIN_CYC cycles after HALT leaves decode until the pipeline is empty
//   CNT_W     width of the saturating stall counter
// Ports:
//   clk, rst (sync, active-low)
//   decode : valid_d, Rs_d, Rt_d, useRs_d, useRt_d, halt_d
//   EX     : Rd_x, RegWrite_x, MemRead_x, nop_x
//   MEM    : Rd_m, RegWrite_m, branchTaken_m
//   memory : imem_busy, dmem_busy
//   outputs: pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, dx_flush,
//            xm_hold, mw_hold (combinational), halted, stall_cnt (registered)
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit FORWARD   = 1'b1,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_d,
    input  logic [REG_W-1:0] Rs_d,
    input  logic [REG_W-1:0] Rt_d,
    input  logic             useRs_d,
    input  logic             useRt_d,
    input  logic             halt_d,
    input  logic [REG_W-1:0] Rd_x,
    input  logic             RegWrite_x,
    input  logic             MemRead_x,
    input  logic             nop_x,
    input  logic [REG_W-1:0] Rd_m,
    input  logic             RegWrite_m,
    input  logic             branchTaken_m,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             pc_hold,
    output logic             fd_hold,
    output logic             fd_flush,
    output logic             dx_hold,
    output logic             dx_bubble,
    output logic             dx_flush,
    output logic             xm_hold,
    output logic             mw_hold,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    ctrl_state_e      state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic ex_wr, match_x, match_m, haz;

    // With forwarding only a load in EX cannot be bypassed in time.
    assign ex_wr = FORWARD ? (RegWrite_x & MemRead_x) : RegWrite_x;

    hazard_cmp u_cmp_ex (
        .rs_i     (Rs_d),
        .rt_i     (Rt_d),
        .use_rs_i (useRs_d),
        .use_rt_i (useRt_d),
        .rd_i     (Rd_x),
        .wr_i     (ex_wr),
        .match_o  (match_x)
    );

    // MEM is only a hazard source without the bypass network.
    hazard_cmp u_cmp_mem (
        .rs_i     (Rs_d),
        .rt_i     (Rt_d),
        .use_rs_i (useRs_d),
        .use_rt_i (useRt_d),
        .rd_i     (Rd_m),
        .wr_i     (RegWrite_m & ~FORWARD),
        .match_o  (match_m)
    );

    assign haz = valid_d & ~nop_x & (match_x | match_m);

    // Priority-ordered stall/flush decode.
    always_comb begin
        pc_hold   = 1'b0;
        fd_hold   = 1'b0;
        fd_flush  = 1'b0;
        dx_hold   = 1'b0;
        dx_bubble = 1'b0;
        dx_flush  = 1'b0;
        xm_hold   = 1'b0;
        mw_hold   = 1'b0;
        if (!rst) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (state_q == ST_HALTED) begin
            pc_hold   = 1'b1;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (dmem_busy) begin
            pc_hold = 1'b1;
            fd_hold = 1'b1;
            dx_hold = 1'b1;
            xm_hold = 1'b1;
            mw_hold = 1'b1;
        end else if (branchTaken_m) begin
            fd_flush  = 1'b1;
            dx_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (state_q == ST_DRAIN || imem_busy) begin
            // Drain behaves like a permanent fetch stall: NOPs into decode.
            pc_hold  = 1'b1;
            fd_flush = 1'b1;
        end else if (haz) begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            dx_bubble = 1'b1;
        end
    end

    // Next-state for the drain sequencer and the stall counter.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        stall_d = stall_q;
        if (state_q != ST_HALTED && pc_hold && stall_q != {CNT_W{1'b1}})
            stall_d = stall_q + 1'b1;
        if (!dmem_busy) begin
            case (state_q)
                ST_RUN: begin
                    if (!branchTaken_m && !imem_busy && !haz && halt_d && valid_d) begin
                        state_d = ST_DRAIN;
                        drain_d = DW'(DRAIN_CYC);
                    end
                end
                ST_DRAIN: begin
                    if (branchTaken_m) begin
                        // HALT was on the wrong path; resume fetching.
                        state_d = ST_RUN;
                        drain_d = '0;
                    end else if (drain_q == DW'(1)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                default: state_d = ST_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    assign halted    = (state_q == ST_HALTED);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share the stimulus:
// dut (FORWARD=1) and dut0 (FORWARD=0). Output vectors are packed as
// {pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, dx_flush, xm_hold, mw_hold}.
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_RST    = 8'b0010_1000;
    localparam logic [7:0] O_STALL  = 8'b1100_1000;
    localparam logic [7:0] O_BRANCH = 8'b0010_1100;
    localparam logic [7:0] O_FREEZE = 8'b1101_0011;
    localparam logic [7:0] O_FETCH  = 8'b1010_0000;
    localparam logic [7:0] O_HALTED = 8'b1010_1000;

    logic clk = 1'b0;
    logic rst;
    logic valid_d, useRs_d, useRt_d, halt_d;
    logic [2:0] Rs_d, Rt_d, Rd_x, Rd_m;
    logic RegWrite_x, MemRead_x, nop_x, RegWrite_m, branchTaken_m;
    logic imem_busy, dmem_busy;

    logic pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, dx_flush, xm_hold, mw_hold, halted;
    logic [15:0] stall_cnt;
    logic pc_hold0, fd_hold0, fd_flush0, dx_hold0, dx_bubble0, dx_flush0, xm_hold0, mw_hold0, halted0;
    logic [15:0] stall_cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FORWARD(1'b1), .DRAIN_CYC(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .Rs_d(Rs_d), .Rt_d(Rt_d),
        .useRs_d(useRs_d), .useRt_d(useRt_d), .halt_d(halt_d), .Rd_x(Rd_x),
        .RegWrite_x(RegWrite_x), .MemRead_x(MemRead_x), .nop_x(nop_x),
        .Rd_m(Rd_m), .RegWrite_m(RegWrite_m), .branchTaken_m(branchTaken_m),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_hold(pc_hold), .fd_hold(fd_hold), .fd_flush(fd_flush),
        .dx_hold(dx_hold), .dx_bubble(dx_bubble), .dx_flush(dx_flush),
        .xm_hold(xm_hold), .mw_hold(mw_hold), .halted(halted), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.FORWARD(1'b0), .DRAIN_CYC(3), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .valid_d(valid_d), .Rs_d(Rs_d), .Rt_d(Rt_d),
        .useRs_d(useRs_d), .useRt_d(useRt_d), .halt_d(halt_d), .Rd_x(Rd_x),
        .RegWrite_x(RegWrite_x), .MemRead_x(MemRead_x), .nop_x(nop_x),
        .Rd_m(Rd_m), .RegWrite_m(RegWrite_m), .branchTaken_m(branchTaken_m),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_hold(pc_hold0), .fd_hold(fd_hold0), .fd_flush(fd_flush0),
        .dx_hold(dx_hold0), .dx_bubble(dx_bubble0), .dx_flush(dx_flush0),
        .xm_hold(xm_hold0), .mw_hold(mw_hold0), .halted(halted0), .stall_cnt(stall_cnt0)
    );

    wire [7:0] outs  = {pc_hold, fd_hold, fd_flush, dx_hold, dx_bubble, dx_flush, xm_hold, mw_hold};
    wire [7:0] outs0 = {pc_hold0, fd_hold0, fd_flush0, dx_hold0, dx_bubble0, dx_flush0, xm_hold0, mw_hold0};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        valid_d = 0; Rs_d = 0; Rt_d = 0; useRs_d = 0; useRt_d = 0; halt_d = 0;
        Rd_x = 0; RegWrite_x = 0; MemRead_x = 0; nop_x = 0;
        Rd_m = 0; RegWrite_m = 0; branchTaken_m = 0; imem_busy = 0; dmem_busy = 0;
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [2:0] r);
        valid_d = 1; useRs_d = 1; Rs_d = r; MemRead_x = 1; RegWrite_x = 1; Rd_x = r;
    endtask

    initial begin
        idle();
        rst = 0;
        #2;
        check("reset_outs", {24'd0, outs}, {24'd0, O_RST});
        tick(); tick();
        check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        rst = 1;
        #1;
        check("idle_outs", {24'd0, outs}, {24'd0, O_NONE});

        // Load-use with forwarding: one stall cycle, then EX holds the bubble.
        load_use(3'd3);
        #1; check("lu_stall", {24'd0, outs}, {24'd0, O_STALL});
        tick();
        nop_x = 1;
        #1; check("lu_release", {24'd0, outs}, {24'd0, O_NONE});
        check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        tick();
        check("lu_cnt_hold", {16'd0, stall_cnt}, 32'd1);

        // invalid decode never stalls
        idle(); load_use(3'd3); valid_d = 0;
        #1; check("invalid_no_stall", {24'd0, outs}, {24'd0, O_NONE});
        tick();

        // R0 dependency is real
        idle(); load_use(3'd0);
        #1; check("r0_stall", {24'd0, outs}, {24'd0, O_STALL});
        tick();
        idle();
        check("r0_cnt", {16'd0, stall_cnt}, 32'd2);

        // ALU RAW: stall only without forwarding, first on EX then on MEM.
        // dut0 has counted 2 stalls so far (both load-use cycles above).
        valid_d = 1; useRt_d = 1; Rt_d = 3'd5; RegWrite_x = 1; Rd_x = 3'd5;
        #1; check("alu_fwd0_N", {24'd0, outs0}, {24'd0, O_STALL});
        check("alu_fwd1_N", {24'd0, outs}, {24'd0, O_NONE});
        tick();
        RegWrite_x = 0; Rd_x = 3'd0; RegWrite_m = 1; Rd_m = 3'd5;
        #1; check("alu_fwd0_N1", {24'd0, outs0}, {24'd0, O_STALL});
        check("alu_fwd1_N1", {24'd0, outs}, {24'd0, O_NONE});
        tick();
        RegWrite_m = 0;
        #1; check("alu_fwd0_N2", {24'd0, outs0}, {24'd0, O_NONE});
        check("alu_fwd0_cnt", {16'd0, stall_cnt0}, 32'd4);
        tick();

        // Branch beats a pending hazard; no stall counted.
        idle(); load_use(3'd3); branchTaken_m = 1;
        #1; check("br_outs", {24'd0, outs}, {24'd0, O_BRANCH});
        tick();
        idle();
        check("br_cnt", {16'd0, stall_cnt}, 32'd2);

        // Imem busy: PC holds, NOP into decode.
        imem_busy = 1;
        #1; check("imem_outs", {24'd0, outs}, {24'd0, O_FETCH});
        tick();
        idle();
        check("imem_cnt", {16'd0, stall_cnt}, 32'd3);

        // dmem_busy freezes a load-use for 4 cycles, then the bubble happens.
        load_use(3'd3); dmem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1; check($sformatf("freeze_%0d", i), {24'd0, outs}, {24'd0, O_FREEZE});
            tick();
        end
        check("freeze_cnt", {16'd0, stall_cnt}, 32'd7);
        dmem_busy = 0;
        #1; check("freeze_then_lu", {24'd0, outs}, {24'd0, O_STALL});
        tick();
        idle();
        check("freeze_lu_cnt", {16'd0, stall_cnt}, 32'd8);

        // HALT drain with one dmem_busy cycle: halted one cycle late.
        valid_d = 1; halt_d = 1;
        #1; check("halt_issue", {24'd0, outs}, {24'd0, O_NONE});
        tick();                                   // c1: DRAIN, cnt 3
        idle();
        #1; check("drain_outs", {24'd0, outs}, {24'd0, O_FETCH});
        tick();                                   // c2: frozen
        dmem_busy = 1;
        #1; check("drain_freeze", {24'd0, outs}, {24'd0, O_FREEZE});
        tick();                                   // c3
        dmem_busy = 0;
        tick();                                   // c4
        check("halt_not_yet", {31'd0, halted}, 32'd0);
        tick();                                   // c5
        check("halt_set", {31'd0, halted}, 32'd1);
        check("halt_outs", {24'd0, outs}, {24'd0, O_HALTED});
        check("halt_cnt", {16'd0, stall_cnt}, 32'd12);
        tick();
        check("halted_no_count", {16'd0, stall_cnt}, 32'd12);

        // Branch during drain cancels the halt.
        rst = 0; tick(); rst = 1;
        check("rst2_cnt", {16'd0, stall_cnt}, 32'd0);
        valid_d = 1; halt_d = 1;
        tick();
        idle(); branchTaken_m = 1;
        #1; check("drain_branch", {24'd0, outs}, {24'd0, O_BRANCH});
        tick();
        idle();
        #1; check("back_to_run", {24'd0, outs}, {24'd0, O_NONE});
        for (int i = 0; i < 5; i++) tick();
        check("cancel_no_halt", {31'd0, halted}, 32'd0);
        check("cancel_cnt", {16'd0, stall_cnt}, 32'd0);

        // Reset mid-drain.
        valid_d = 1; halt_d = 1;
        tick();
        idle();
        tick();
        check("mid_drain_cnt", {16'd0, stall_cnt}, 32'd1);
        rst = 0; tick(); rst = 1;
        #1; check("rst_drain_outs", {24'd0, outs}, {24'd0, O_NONE});
        check("rst_drain_cnt", {16'd0, stall_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("rst_drain_halted", {31'd0, halted}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
